// File: rtl/mouse_pkg.sv
// Shared constants for the PS/2 mouse tracker: frame geometry, receiver
// state encoding and the bit layout of the packet status byte.
package mouse_pkg;

  localparam int FRAME_LEN = 11;
  localparam int DATA_BITS = FRAME_LEN - 3;

  localparam int B0_L    = 0;
  localparam int B0_R    = 1;
  localparam int B0_M    = 2;
  localparam int B0_SYNC = 3;
  localparam int B0_XS   = 4;
  localparam int B0_YS   = 5;
  localparam int B0_XO   = 6;
  localparam int B0_YO   = 7;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: pin synchronizers, falling-edge detect, frame FSM with
// odd-parity/stop check and an idle timeout that abandons stalled transfers.
module ps2_rx
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       pkt_busy_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frm_err_o,
  output logic       tmo_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic            clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic            fall_q, smp_q;
  rx_state_e       state_q, state_d;
  logic [7:0]      sr_q, sr_d;
  logic [2:0]      bit_q, bit_d;
  logic            par_q, par_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  // Timeout only runs while a frame or a multi-byte packet is in flight.
  logic active;
  assign active = (state_q != RX_IDLE) || pkt_busy_i;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_d      = bit_q;
    par_d      = par_q;
    tmo_d      = tmo_q;
    byte_vld_o = 1'b0;
    frm_err_o  = 1'b0;
    tmo_o      = 1'b0;
    if (fall_q) begin
      tmo_d = '0;
      case (state_q)
        RX_IDLE: begin
          if (!smp_q) begin
            state_d = RX_DATA;
            bit_d   = '0;
          end
        end
        RX_DATA: begin
          sr_d  = {smp_q, sr_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = smp_q;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (smp_q && (^{sr_q, par_q})) byte_vld_o = 1'b1;
          else                            frm_err_o  = 1'b1;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (active) begin
      if (tmo_q == TMO_LAST) begin
        tmo_o   = 1'b1;
        tmo_d   = '0;
        state_d = RX_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      fall_q     <= 1'b0;
      smp_q      <= 1'b1;
      state_q    <= RX_IDLE;
      bit_q      <= '0;
      tmo_q      <= '0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
      fall_q     <= clk_prev_q & ~clk_s2_q;
      smp_q      <= dat_s2_q;
      state_q    <= state_d;
      bit_q      <= bit_d;
      tmo_q      <= tmo_d;
    end
  end

  always_ff @(posedge clk) begin
    sr_q  <= sr_d;
    par_q <= par_d;
  end

  assign byte_o = sr_q;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse tracker: assembles 3-byte packets, applies clamped movement to
// the cursor, tracks buttons and packs a 32-bit word for the hex display.
module ps2_mouse_tracker
  import mouse_pkg::*;
#(
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic [2:0]  buttons,
  output logic        pkt_valid,
  output logic        frame_err,
  output logic [31:0] disp_word
);

  logic [7:0] rx_byte;
  logic       rx_vld, rx_err, rx_tmo;
  logic [1:0] idx_q, idx_d;
  logic [7:0] b0_q, b0_d, b1_q, b1_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [2:0]  btn_q, btn_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pv_q, pv_d, fe_q, fe_d;
  logic [8:0]  dx, dy;
  logic signed [13:0] x_sum, y_sum;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .pkt_busy_i (idx_q != 2'd0),
    .byte_o     (rx_byte),
    .byte_vld_o (rx_vld),
    .frm_err_o  (rx_err),
    .tmo_o      (rx_tmo)
  );

  function automatic logic [11:0] clamp(input logic signed [13:0] v, input int hi);
    if (v < 0) return 12'd0;
    if (int'(v) > hi) return 12'(hi);
    return v[11:0];
  endfunction

  // dy comes straight from the incoming third byte so the update lands
  // in the cycle right after the stop bit.
  assign dx    = {b0_q[B0_XS], b1_q};
  assign dy    = {b0_q[B0_YS], rx_byte};
  assign x_sum = {2'b00, x_q} + {{5{dx[8]}}, dx};
  assign y_sum = {2'b00, y_q} - {{5{dy[8]}}, dy};

  always_comb begin
    idx_d = idx_q;
    b0_d  = b0_q;
    b1_d  = b1_q;
    x_d   = x_q;
    y_d   = y_q;
    btn_d = btn_q;
    cnt_d = cnt_q;
    pv_d  = 1'b0;
    fe_d  = rx_err;
    if (rx_err || rx_tmo) begin
      idx_d = 2'd0;
    end else if (rx_vld) begin
      case (idx_q)
        2'd0: begin
          if (rx_byte[B0_SYNC]) begin
            b0_d  = rx_byte;
            idx_d = 2'd1;
          end
        end
        2'd1: begin
          b1_d  = rx_byte;
          idx_d = 2'd2;
        end
        default: begin
          if (!b0_q[B0_XO]) x_d = clamp(x_sum, X_MAX);
          if (!b0_q[B0_YO]) y_d = clamp(y_sum, Y_MAX);
          btn_d = {b0_q[B0_M], b0_q[B0_R], b0_q[B0_L]};
          cnt_d = cnt_q + 4'd1;
          pv_d  = 1'b1;
          idx_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= 2'd0;
      x_q   <= 12'(X_MAX / 2);
      y_q   <= 12'(Y_MAX / 2);
      btn_q <= 3'd0;
      cnt_q <= 4'd0;
      pv_q  <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      x_q   <= x_d;
      y_q   <= y_d;
      btn_q <= btn_d;
      cnt_q <= cnt_d;
      pv_q  <= pv_d;
      fe_q  <= fe_d;
    end
  end

  always_ff @(posedge clk) begin
    b0_q <= b0_d;
    b1_q <= b1_d;
  end

  assign x_pos     = x_q;
  assign y_pos     = y_q;
  assign buttons   = btn_q;
  assign pkt_valid = pv_q;
  assign frame_err = fe_q;
  assign disp_word = {1'b0, btn_q, x_q, y_q, cnt_q};

endmodule
